// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among CORE_COUNT cores. It has a 2-cycle read return path.
// Defining RAM_ARB_FIXED_PRIO_EN switches to fixed priority, where the lowest index wins and there is no rotation pointer.
module ram_arbiter #(
  parameter int CORE_COUNT = 4,
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic [CORE_COUNT-1:0]            req,
  input  logic [CORE_COUNT-1:0]            wrEn,
  input  logic [CORE_COUNT*ADDR_WIDTH-1:0] addr,
  input  logic [CORE_COUNT*WIDTH-1:0]      dataIn,
  output logic [CORE_COUNT-1:0]            grant,
  output logic [CORE_COUNT-1:0]            rdValid,
  output logic [WIDTH-1:0]                 rdData,
  output logic                             ram_wrEn,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic [WIDTH-1:0]                 ram_dataIn,
  input  logic [WIDTH-1:0]                 ram_dataOut
);

  localparam int IDX_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

  // Handshake: a core holds req/wrEn/addr/dataIn stable until it sees grant.
  // The transfer happens in the cycle where req[i] & grant[i] is true.
  // A write completes at grant; a read returns on rdValid[i] two cycles later.
  logic                  hit;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_data;
  logic [CORE_COUNT-1:0] tag1;
  logic [CORE_COUNT-1:0] tag2;

`ifdef RAM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant    = '0;
    hit      = 1'b0;
    sel_idx  = '0;
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      if (!hit && req[i]) begin
        hit      = 1'b1;
        grant[i] = 1'b1;
        sel_idx  = IDX_W'(i);
        sel_wr   = wrEn[i];
        sel_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = dataIn[i*WIDTH +: WIDTH];
      end
    end
  end
`else
  logic [IDX_W-1:0] last;

  // Search begins one past the last winner, so the previous winner has the lowest priority.
  always_comb begin
    grant    = '0;
    hit      = 1'b0;
    sel_idx  = '0;
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int off = 1; off <= CORE_COUNT; off++) begin
      int cand;
      cand = (int'(last) + off) % CORE_COUNT;
      if (!hit && req[cand]) begin
        hit         = 1'b1;
        grant[cand] = 1'b1;
        sel_idx     = IDX_W'(cand);
        sel_wr      = wrEn[cand];
        sel_addr    = addr[cand*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data    = dataIn[cand*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      last <= IDX_W'(CORE_COUNT - 1);
    end else if (hit) begin
      last <= sel_idx;
    end
  end
`endif

  // When no core is granted, addr/data hold and only the write strobe drops.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ram_wrEn   <= 1'b0;
      ram_addr   <= '0;
      ram_dataIn <= '0;
      tag1       <= '0;
      tag2       <= '0;
    end else begin
      tag2 <= tag1;
      if (hit) begin
        ram_wrEn   <= sel_wr;
        ram_addr   <= sel_addr;
        ram_dataIn <= sel_data;
        tag1       <= sel_wr ? '0 : grant;
      end else begin
        ram_wrEn <= 1'b0;
        tag1     <= '0;
      end
    end
  end

  assign rdValid = tag2;
  assign rdData  = ram_dataOut;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural RAM, a grant/read scoreboard and directed and random scenarios.
// Define RAM_ARB_FIXED_PRIO_EN on the bench as well when building the fixed-priority variant.
module tb_ram_arbiter;

  localparam int N  = 4;
  localparam int W  = 12;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            rstN = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    wrEn = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*W-1:0]  dataIn = '0;
  logic [N-1:0]    grant;
  logic [N-1:0]    rdValid;
  logic [W-1:0]    rdData;
  logic            ram_wrEn;
  logic [AW-1:0]   ram_addr;
  logic [W-1:0]    ram_dataIn;
  logic [W-1:0]    ram_dataOut;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ram_arbiter #(.CORE_COUNT(N), .WIDTH(W), .DEPTH(256)) dut (
    .clk(clk), .rstN(rstN), .req(req), .wrEn(wrEn), .addr(addr), .dataIn(dataIn),
    .grant(grant), .rdValid(rdValid), .rdData(rdData), .ram_wrEn(ram_wrEn),
    .ram_addr(ram_addr), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
  );

  // ---------------- clock / behavioural RAM ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0]  mem [256];
  logic [AW-1:0] mem_addr_q = '0;
  always @(posedge clk) begin
    if (ram_wrEn) mem[ram_addr] <= ram_dataIn;
    mem_addr_q <= ram_addr;
  end
  assign ram_dataOut = mem[mem_addr_q];

  // ---------------- scoreboard ----------------
  logic [W-1:0]  shadow [256];
  logic [W-1:0]  exp_q[$];
  logic [N-1:0]  core_q[$];
  int            due_q[$];
  int            m_last = N - 1;
  logic          wr_pend = 1'b0;
  logic [AW-1:0] wr_a;
  logic [W-1:0]  wr_d;

  function automatic int model_pick(input logic [N-1:0] r, input int lst);
`ifdef RAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int off = 1; off <= N; off++) if (r[(lst + off) % N]) return (lst + off) % N;
`endif
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] exp_core;
    logic [N-1:0] exp_g;
    logic [W-1:0] exp_d;
    int k;
    if (!rstN) begin
      exp_q.delete(); core_q.delete(); due_q.delete();
      wr_pend = 1'b0;
      m_last  = N - 1;
      checks++;
      if (rdValid !== '0) begin
        errors++;
        $display("FAIL rdvalid_in_reset got=%b exp=0000", rdValid);
      end
    end else begin
      // a write lands in the RAM at the end of the cycle after its grant
      if (wr_pend) begin
        shadow[wr_a] = wr_d;
        wr_pend = 1'b0;
      end
      checks++;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        exp_core = core_q.pop_front();
        exp_d    = exp_q.pop_front();
        void'(due_q.pop_front());
        if (rdValid !== exp_core || rdData !== exp_d) begin
          errors++;
          $display("FAIL read_return cyc=%0d got=%b/%h exp=%b/%h", cyc, rdValid, rdData, exp_core, exp_d);
        end
      end else if (rdValid !== '0) begin
        errors++;
        $display("FAIL spurious_rdvalid cyc=%0d got=%b exp=0000", cyc, rdValid);
      end
      k = model_pick(req, m_last);
      exp_g = (k < 0) ? '0 : (N'(1) << k);
      checks++;
      if (grant !== exp_g) begin
        errors++;
        $display("FAIL grant cyc=%0d req=%b got=%b exp=%b", cyc, req, grant, exp_g);
      end
      if (k >= 0) begin
`ifndef RAM_ARB_FIXED_PRIO_EN
        m_last = k;
`endif
        if (wrEn[k]) begin
          wr_pend = 1'b1;
          wr_a    = addr[k*AW +: AW];
          wr_d    = dataIn[k*W +: W];
        end else begin
          exp_q.push_back(shadow[addr[k*AW +: AW]]);
          core_q.push_back(exp_g);
          due_q.push_back(cyc + 2);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int i, input logic rq, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
    req[i]              = rq;
    wrEn[i]             = we;
    addr[i*AW +: AW]    = a;
    dataIn[i*W +: W]    = d;
  endtask

  task automatic reset_dut();
    tick();
    req  = '0;
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (ram_wrEn !== 1'b0 || ram_addr !== '0 || ram_dataIn !== '0 || rdValid !== '0) begin
        errors++;
        $display("FAIL reset_outputs got=%b/%h/%h/%b exp=0/00/000/0000", ram_wrEn, ram_addr, ram_dataIn, rdValid);
      end
    end
    tick();
    rstN = 1'b1;
    // mid-stream: put a write on the RAM port, then reset while addr/data hold it
    tick();
    set_core(0, 1'b1, 1'b1, 8'h20, 12'hFFF);
    set_core(1, 1'b1, 1'b0, 8'h03, 12'h000);
    @(negedge clk);
    tick();
    req = '0;
    tick();
    rstN = 1'b0;
    #1;
    checks++;
    if (ram_wrEn !== 1'b0 || ram_addr !== '0 || ram_dataIn !== '0 || rdValid !== '0) begin
      errors++;
      $display("FAIL reset_midstream got=%b/%h/%h/%b exp=0/00/000/0000", ram_wrEn, ram_addr, ram_dataIn, rdValid);
    end
    tick();
    rstN = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rdValid !== '0) begin
        errors++;
        $display("FAIL post_reset_rdvalid got=%b exp=0000", rdValid);
      end
    end
  endtask

  task automatic test_single_core();
    tick();
    set_core(1, 1'b1, 1'b1, 8'h10, 12'hABC);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL single_write_grant got=%b exp=0010", grant);
    end
    tick();
    set_core(1, 1'b1, 1'b0, 8'h10, 12'h000);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL single_read_grant got=%b exp=0010", grant);
    end
    tick();
    req = '0;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if (rdValid !== 4'b0010 || rdData !== 12'hABC) begin
      errors++;
      $display("FAIL single_read_data got=%b/%h exp=0010/abc", rdValid, rdData);
    end
  endtask

  task automatic test_round_robin();
    reset_dut();
    for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b0, AW'(i), 12'h000);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      checks++;
      if (grant !== (4'b0001 << (n % N))) begin
        errors++;
        $display("FAIL rr_grant n=%0d got=%b exp=%b", n, grant, 4'b0001 << (n % N));
      end
      tick();
    end
    req = '0;
    repeat (3) tick();
  endtask

  task automatic test_fixed_prio();
    reset_dut();
    set_core(0, 1'b1, 1'b0, 8'h01, 12'h000);
    set_core(3, 1'b1, 1'b0, 8'h02, 12'h000);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      checks++;
      if (grant !== 4'b0001) begin
        errors++;
        $display("FAIL fixed_grant n=%0d got=%b exp=0001", n, grant);
      end
      tick();
    end
    req = '0;
    repeat (3) tick();
  endtask

  task automatic test_raw();
    set_core(0, 1'b1, 1'b1, 8'h07, 12'h555);
    set_core(2, 1'b1, 1'b0, 8'h07, 12'h000);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL raw_first got=%b exp=0001", grant);
    end
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL raw_second got=%b exp=0100", grant);
    end
    tick();
    req = '0;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if (rdValid !== 4'b0100 || rdData !== 12'h555) begin
      errors++;
      $display("FAIL raw_data got=%b/%h exp=0100/555", rdValid, rdData);
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    logic [N-1:0] g;
    // read dropped while its address is on the RAM port
    set_core(3, 1'b1, 1'b0, 8'h05, 12'h000);
    @(negedge clk);
    tick();
    req = '0;
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rdValid !== '0) begin
        errors++;
        $display("FAIL dropped_read got=%b exp=0000", rdValid);
      end
    end
    // write cancelled while on the RAM port
    tick();
    set_core(1, 1'b1, 1'b1, 8'h09, 12'h777);
    @(negedge clk);
    tick();
    req = '0;
    checks++;
    if (ram_wrEn !== 1'b1 || ram_addr !== 8'h09) begin
      errors++;
      $display("FAIL write_presented got=%b/%h exp=1/09", ram_wrEn, ram_addr);
    end
    rstN = 1'b0;
    #1;
    checks++;
    if (ram_wrEn !== 1'b0) begin
      errors++;
      $display("FAIL write_cancel got=%b exp=0", ram_wrEn);
    end
    tick();
    rstN = 1'b1;
    for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b0, AW'(9 + i), 12'h000);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL post_reset_grant got=%b exp=0001", grant);
    end
    for (int n = 0; n < 6; n++) begin
      g = req & grant;
      tick();
      req = req & ~g;
      @(negedge clk);
    end
    req = '0;
    repeat (3) tick();
  endtask

  task automatic test_random();
    logic [N-1:0] hs;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      hs = req & grant;
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req[i] || hs[i]) begin
          if ($urandom_range(0, 2) == 0)
            set_core(i, 1'b0, 1'b0, 8'h00, 12'h000);
          else
            set_core(i, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 12'($urandom_range(0, 4095)));
        end
      end
    end
    req = '0;
    repeat (4) tick();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem[a]    = 12'h100 + 12'(a);
      shadow[a] = 12'h100 + 12'(a);
    end
    test_reset();
    test_single_core();
`ifdef RAM_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_round_robin();
`endif
    test_raw();
    test_reset_inflight();
    test_random();
    repeat (4) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reads_outstanding got=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
